// File: rtl/project_pkg.sv
// Shared types and constants for the SRAM stage sequencer and its helpers.
package project_pkg;

    localparam int SRAM_ADDR_W = 18;
    localparam int SRAM_DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_UART_RX  = 3'd1,
        S_M1_START = 3'd2,
        S_M1_WAIT  = 3'd3,
        S_M2_START = 3'd4,
        S_M2_WAIT  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/uart_timeout_counter.sv
// Idle-cycle counter for UART end-of-file detection; expired_o is high while
// the count sits at TERMINAL_COUNT-1. Clear has priority over enable.
module uart_timeout_counter #(
    parameter int unsigned TERMINAL_COUNT = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CNT_W = (TERMINAL_COUNT > 1) ? $clog2(TERMINAL_COUNT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TERMINAL_COUNT - 1);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == LAST);

endmodule

// File: rtl/sram_stage_sequencer.sv
// Top sequencer: UART load -> M1 -> M2 -> VGA, owning the shared SRAM port.
// Define SEQ_CYCLE_COUNT_EN to build the M1+M2 decode cycle counter.
//
// state      | meaning
// S_IDLE     | VGA owns SRAM, waiting for a UART start bit
// S_UART_RX  | UART owns SRAM, timing out idle writes
// S_M1_START | one cycle, M1 start pulse queued, writes blocked
// S_M1_WAIT  | M1 owns SRAM until M1_done
// S_M2_START | one cycle, M2 start pulse queued, writes blocked
// S_M2_WAIT  | M2 owns SRAM until M2_done
module sram_stage_sequencer
    import project_pkg::*;
#(
    parameter int unsigned UART_TIMEOUT_CYCLES = 50_000_000
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    input  logic                   UART_RX_I,
    input  logic                   UART_we_n,
    input  logic [SRAM_ADDR_W-1:0] UART_address,
    input  logic [SRAM_DATA_W-1:0] UART_write_data,
    output logic                   UART_rx_initialize,
    output logic                   UART_rx_enable,
    output logic                   M1_start,
    output logic                   M2_start,
    input  logic                   M1_done,
    input  logic                   M2_done,
    input  logic [SRAM_ADDR_W-1:0] M1_address,
    input  logic [SRAM_ADDR_W-1:0] M2_address,
    input  logic [SRAM_DATA_W-1:0] M1_write_data,
    input  logic [SRAM_DATA_W-1:0] M2_write_data,
    input  logic                   M1_we_n,
    input  logic                   M2_we_n,
    input  logic [SRAM_ADDR_W-1:0] VGA_address,
    output logic                   VGA_enable,
    output logic [SRAM_ADDR_W-1:0] SRAM_address,
    output logic [SRAM_DATA_W-1:0] SRAM_write_data,
    output logic                   SRAM_we_n,
    output logic [2:0]             seq_state,
    output logic                   busy,
    output logic [31:0]            decode_cycles
);

    seq_state_t state_q, state_d;
    logic init_q, init_d;
    logic rx_en_q, rx_en_d;
    logic m1_start_q, m1_start_d;
    logic m2_start_q, m2_start_d;
    logic vga_en_q, vga_en_d;
    logic timer_clear, timer_en, timer_expired;

    uart_timeout_counter #(
        .TERMINAL_COUNT(UART_TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (Clock),
        .rst_ni   (Resetn),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expired_o(timer_expired)
    );

    always_comb begin
        state_d     = state_q;
        init_d      = 1'b0;
        rx_en_d     = 1'b0;
        m1_start_d  = 1'b0;
        m2_start_d  = 1'b0;
        vga_en_d    = vga_en_q;
        timer_clear = 1'b0;
        timer_en    = 1'b0;
        case (state_q)
            S_IDLE: begin
                timer_clear = 1'b1;
                if (!UART_RX_I) begin
                    init_d   = 1'b1;
                    vga_en_d = 1'b0;
                    state_d  = S_UART_RX;
                end
            end
            S_UART_RX: begin
                rx_en_d     = init_q;
                timer_en    = 1'b1;
                timer_clear = !UART_we_n;
                // a write landing on the terminal cycle restarts the wait
                if (timer_expired && UART_we_n) begin
                    state_d = S_M1_START;
                end
            end
            S_M1_START: begin
                m1_start_d = 1'b1;
                state_d    = S_M1_WAIT;
            end
            S_M1_WAIT: begin
                if (M1_done) begin
                    state_d = S_M2_START;
                end
            end
            S_M2_START: begin
                m2_start_d = 1'b1;
                state_d    = S_M2_WAIT;
            end
            S_M2_WAIT: begin
                if (M2_done) begin
                    state_d  = S_IDLE;
                    vga_en_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q    <= S_IDLE;
            init_q     <= 1'b0;
            rx_en_q    <= 1'b0;
            m1_start_q <= 1'b0;
            m2_start_q <= 1'b0;
            vga_en_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            init_q     <= init_d;
            rx_en_q    <= rx_en_d;
            m1_start_q <= m1_start_d;
            m2_start_q <= m2_start_d;
            vga_en_q   <= vga_en_d;
        end
    end

    always_comb begin
        SRAM_address    = VGA_address;
        SRAM_write_data = '0;
        SRAM_we_n       = 1'b1;
        case (state_q)
            S_UART_RX: begin
                SRAM_address    = UART_address;
                SRAM_write_data = UART_write_data;
                SRAM_we_n       = UART_we_n;
            end
            S_M1_START: begin
                SRAM_address    = M1_address;
                SRAM_write_data = M1_write_data;
            end
            S_M1_WAIT: begin
                SRAM_address    = M1_address;
                SRAM_write_data = M1_write_data;
                SRAM_we_n       = M1_we_n;
            end
            S_M2_START: begin
                SRAM_address    = M2_address;
                SRAM_write_data = M2_write_data;
            end
            S_M2_WAIT: begin
                SRAM_address    = M2_address;
                SRAM_write_data = M2_write_data;
                SRAM_we_n       = M2_we_n;
            end
            default: ;
        endcase
    end

    assign UART_rx_initialize = init_q;
    assign UART_rx_enable     = rx_en_q;
    assign M1_start           = m1_start_q;
    assign M2_start           = m2_start_q;
    assign VGA_enable         = vga_en_q;
    assign seq_state          = state_q;
    assign busy               = (state_q != S_IDLE);

`ifdef SEQ_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;
    logic        in_decode;

    assign in_decode = (state_q == S_M1_START) || (state_q == S_M1_WAIT) ||
                       (state_q == S_M2_START) || (state_q == S_M2_WAIT);

    always_comb begin
        cyc_d = cyc_q;
        if ((state_d == S_M1_START) && (state_q != S_M1_START)) begin
            cyc_d = '0;
        end else if (in_decode && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            cyc_q <= '0;
        end else begin
            cyc_q <= cyc_d;
        end
    end

    assign decode_cycles = cyc_q;
`else
    assign decode_cycles = '0;
`endif

endmodule
